// File: rtl/passthrough_pkg.sv
// rtl/passthrough_pkg.sv - shared mode encodings for passthrough_pipe
package passthrough_pkg;

   localparam int MODE_W = 2;

   typedef enum logic [MODE_W-1:0] {
      MODE_PASS = 2'b00,
      MODE_INV  = 2'b01,
      MODE_NEG  = 2'b10,
      MODE_ZERO = 2'b11
   } mode_e;

endpackage

// File: rtl/passthrough_pipe_if.sv
// rtl/passthrough_pipe_if.sv - producer/consumer handshake bundle for passthrough_pipe
interface passthrough_pipe_if
   import passthrough_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int OUT_WIDTH = 4
) ();

   logic signed [WIDTH-1:0]     in1;
   logic        [MODE_W-1:0]    mode;
   logic                        in_valid;
   logic                        in_ready;
   logic signed [OUT_WIDTH-1:0] result;
   logic                        out_valid;
   logic                        out_ready;

   // Environment side: drives operands and consumer backpressure.
   modport master (
      output in1, mode, in_valid, out_ready,
      input  in_ready, result, out_valid
   );

   // Pipeline side.
   modport slave (
      input  in1, mode, in_valid, out_ready,
      output in_ready, result, out_valid
   );

endinterface

// File: rtl/passthrough_pipe_stage.sv
// rtl/passthrough_pipe_stage.sv - one valid/ready register slice of the pipe
module pipe_stage #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  flush,
   input  logic                  down_ready,
   input  logic                  up_valid,
   input  logic [DATA_WIDTH-1:0] up_data,
   output logic                  valid,
   output logic [DATA_WIDTH-1:0] data
);

   logic                  valid_q, valid_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  load;

   // Load when empty or when downstream takes our item; a bubble keeps old data.
   always_comb begin
      load    = !valid_q || down_ready;
      valid_d = valid_q;
      data_d  = data_q;
      if (load) begin
         valid_d = up_valid;
         if (up_valid) begin
            data_d = up_data;
         end
      end
      if (flush) begin
         valid_d = 1'b0;
      end
   end

   // Stage registers; reset clears both valid and data.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   assign valid = valid_q;
   assign data  = data_q;

endmodule

// File: rtl/passthrough_pipe.sv
// rtl/passthrough_pipe.sv - mode decode, sign extension and DEPTH-stage elastic pipe
module passthrough_pipe
   import passthrough_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int OUT_WIDTH = 4,
   parameter int DEPTH     = 2
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush,
   passthrough_pipe_if.slave          bus,
   output logic [$clog2(DEPTH+1)-1:0] count
);

   localparam int CW = $clog2(DEPTH + 1);

   if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
      $error("passthrough_pipe: WIDTH must be in 2..32");
   end
   if (OUT_WIDTH < WIDTH) begin : g_bad_out_width
      $error("passthrough_pipe: OUT_WIDTH must be >= WIDTH");
   end
   if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
      $error("passthrough_pipe: DEPTH must be in 1..8");
   end

   logic signed [WIDTH-1:0]     op_val;
   logic signed [OUT_WIDTH-1:0] ext_val;
   logic        [DEPTH:0]       ready_vec;
   logic        [DEPTH-1:0]     valid_vec;
   logic        [OUT_WIDTH-1:0] data_arr [DEPTH];
   logic                        s0_valid;

   // Apply the operation in WIDTH bits, then sign-extend once before stage 0.
   always_comb begin
      op_val = '0;
      case (mode_e'(bus.mode))
         MODE_PASS: op_val = bus.in1;
         MODE_INV:  op_val = ~bus.in1;
         MODE_NEG:  op_val = -bus.in1;
         MODE_ZERO: op_val = '0;
         default:   op_val = '0;
      endcase
      ext_val = OUT_WIDTH'(op_val);
   end

   // Ready ripples back from the consumer; an empty stage is always ready.
   always_comb begin
      ready_vec        = '0;
      ready_vec[DEPTH] = bus.out_ready;
      for (int k = DEPTH - 1; k >= 0; k--) begin
         ready_vec[k] = !valid_vec[k] || ready_vec[k+1];
      end
   end

   assign bus.in_ready = ready_vec[0] && !flush && !rst;
   assign s0_valid     = bus.in_valid && bus.in_ready;

   for (genvar k = 0; k < DEPTH; k++) begin : g_stage
      logic                 up_valid;
      logic [OUT_WIDTH-1:0] up_data;

      if (k == 0) begin : g_first
         assign up_valid = s0_valid;
         assign up_data  = ext_val;
      end else begin : g_rest
         assign up_valid = valid_vec[k-1];
         assign up_data  = data_arr[k-1];
      end

      pipe_stage #(
         .DATA_WIDTH (OUT_WIDTH)
      ) u_stage (
         .clk        (clk),
         .rst        (rst),
         .flush      (flush),
         .down_ready (ready_vec[k+1]),
         .up_valid   (up_valid),
         .up_data    (up_data),
         .valid      (valid_vec[k]),
         .data       (data_arr[k])
      );
   end

   assign bus.out_valid = valid_vec[DEPTH-1];
   assign bus.result    = data_arr[DEPTH-1];

   // Occupancy is the population count of the stage valid bits.
   always_comb begin
      count = '0;
      for (int k = 0; k < DEPTH; k++) begin
         count = count + CW'(valid_vec[k]);
      end
   end

endmodule

// File: doc/passthrough_pipe.md
PASSTHROUGH_PIPE -- requirements
Module: passthrough_pipe

Interface
REQ-001 Parameter WIDTH, default 4: input operand width in bits; legal range 2..32.
REQ-002 Parameter OUT_WIDTH, default 4: result width in bits; SHALL be >= WIDTH; elaboration error otherwise.
REQ-003 Parameter DEPTH, default 2: number of register stages; legal range 1..8.
REQ-004 Port: clk  input  1  sole clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  synchronous, active-high reset.
REQ-006 Port: in1  input  WIDTH  signed operand.
REQ-007 Port: mode  input  2  operation, captured together with in1.
REQ-008 Port: in_valid  input  1  in1/mode valid this cycle.
REQ-009 Port: in_ready  output  1  block accepts in1 this cycle.
REQ-010 Port: flush  input  1  discard all in-flight data.
REQ-011 Port: result  output  OUT_WIDTH  signed output data.
REQ-012 Port: out_valid  output  1  result valid this cycle.
REQ-013 Port: out_ready  input  1  consumer accepts result this cycle.
REQ-014 Port: count  output  $clog2(DEPTH+1)  number of occupied stages.

Function
REQ-015 Transfer in SHALL occur when in_valid && in_ready at a rising edge; transfer out when out_valid && out_ready.
REQ-016 Mode 00 PASS: result = sign-extended in1.
REQ-017 Mode 01 INV: result = sign-extended bitwise NOT of in1.
REQ-018 Mode 10 NEG: result = sign-extended two's-complement negation of in1 in WIDTH bits; most-negative value wraps to itself (4'b1000 -> 4'b1000).
REQ-019 Mode 11 ZERO: result = 0.
REQ-020 Mode operation SHALL be applied in stage 0; later stages only carry data; sign extension to OUT_WIDTH SHALL be applied in stage 0.
REQ-021 Stage k SHALL load when it is empty or stage k+1 is loading/accepting (last stage: out_ready); in_ready = stage 0 load condition && !flush.
REQ-022 Unstalled latency SHALL be exactly DEPTH cycles from input transfer to out_valid; throughput one item per cycle.
REQ-023 Bubbles SHALL collapse: an empty stage accepts from upstream even while downstream is stalled.
REQ-024 Full condition (count == DEPTH, out_ready low): in_ready low; no stage changes; result and out_valid held stable.
REQ-025 Empty condition: out_valid low; result holds last value.
REQ-026 Order SHALL be preserved; no item dropped or duplicated except by flush or rst.
REQ-027 Simultaneous input and output transfer when full SHALL keep count unchanged.
REQ-028 count SHALL equal the number of stage valid bits set, updated on the same edge as the valids.
REQ-029 flush high at an edge SHALL clear all stage valids; input that cycle not accepted; output transfer that cycle still counts as completed if out_valid && out_ready.
REQ-030 flush and rst high together: rst takes precedence (identical visible effect).

Reset
REQ-031 rst high at an edge SHALL clear all valid bits, stage data and result to 0, count to 0, out_valid to 0.
REQ-032 in_ready SHALL be low while rst is high, and high in the first cycle after rst deasserts.
REQ-033 rst mid-operation SHALL discard all in-flight items with no partial output.

Structure
REQ-034 Shared package passthrough_pkg SHALL hold mode encodings (MODE_PASS, MODE_INV, MODE_NEG, MODE_ZERO) and the mode enum typedef.
REQ-035 One sub-module pipe_stage (parametrised data width; valid/ready register slice) SHALL be instantiated DEPTH times via generate.
REQ-036 Mode decode and sign extension SHALL live in the top level before stage 0.

Verification (WIDTH=4, OUT_WIDTH=8, DEPTH=2 unless noted)
REQ-037 PASS 4'b1111, out_ready high -> result 8'hFF, out_valid high exactly 2 cycles after transfer.
REQ-038 INV 4'b1010 -> 8'h05; NEG 4'b1000 -> 8'hF8; NEG 4'b0011 -> 8'hFD; ZERO 4'b0111 -> 8'h00.
REQ-039 out_ready low, push 0001,0010,0011 -> first two accepted, in_ready low, count=2; raise out_ready -> 8'h01, 8'h02, 8'h03 in order.
REQ-040 Stream of 4 items, flush after 2nd transfer -> count=0 next cycle, no flushed item appears, next pushed item emerges after 2 cycles.
REQ-041 rst during stalled full pipe -> result=0, out_valid=0, count=0 next cycle, in_ready high after release.
REQ-042 DEPTH=1, WIDTH=OUT_WIDTH=4: continuous PASS stream 0000..1111 with out_ready high -> one result per cycle, latency 1.
